lock_reg_readback: RTL and testbench

- Read-side responder for a bank of lock-protected configuration registers whose write path is gated by a sticky lock bit.
- Accepts single-beat read requests over a valid/ready handshake and returns register contents with an error flag.
- Withholds registers marked secret once the bank is locked, counts denied reads, and raises a sticky lockout alarm after repeated denials.
- Sits beside the lockable write path and samples its register outputs and lock_status directly.

---
 rtl/lock_reg_readback.sv | 149 ++++++++++++++
 tb/tb_lock_reg_readback.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lock_reg_readback.sv
// Read-side responder for a lock-protected register bank: withholds secret registers while locked,
// counts denials and raises a sticky lockout alarm. Optional macro: DEBUG_READ_BYPASS_EN (debug unlock bypass).
module lock_reg_readback #(
    parameter int                     DATA_W      = 32,
    parameter int                     NUM_REGS    = 4,
    parameter int                     ADDR_W      = 4,
    parameter logic [NUM_REGS-1:0]    SECRET_MASK = 4'b1000,
    parameter int                     DENY_LIMIT  = 3
) (
    input  logic                       Clk,
    input  logic                       resetn,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data_flat,
    input  logic                       lock_status,
    input  logic                       debug_unlocked,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_err,
    input  logic                       rd_resp_ready,
    output logic [7:0]                 deny_cnt,
    output logic                       lockout_alarm
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

    localparam logic [7:0] DENY_LIMIT_C = 8'(DENY_LIMIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [7:0]          deny_q, deny_d;
    logic [7:0]          consec_q, consec_d;
    logic                alarm_q, alarm_d;

    logic                addr_hit;
    logic                addr_secret;
    logic [DATA_W-1:0]   sel_data;
    logic                secret_block;
    logic                deny;
    logic [7:0]          consec_inc;

    // Decode the latched index without comparing mismatched widths against NUM_REGS.
    always_comb begin
        addr_hit    = 1'b0;
        addr_secret = 1'b0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == i[ADDR_W-1:0]) begin
                addr_hit    = 1'b1;
                addr_secret = SECRET_MASK[i];
                sel_data    = reg_data_flat[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DEBUG_READ_BYPASS_EN
    assign secret_block = addr_secret & lock_status & ~debug_unlocked;
`else
    assign secret_block = addr_secret & lock_status;
    wire   unused_debug_unlocked = debug_unlocked;
`endif

    assign consec_inc = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        deny_d   = deny_q;
        consec_d = consec_q;
        alarm_d  = alarm_q;
        deny     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = RESP;
                data_d  = '0;
                err_d   = 1'b1;
                if (alarm_q) begin
                    deny = 1'b1;
                end else if (!addr_hit) begin
                    deny = 1'b0;
                end else if (secret_block) begin
                    deny = 1'b1;
                end else begin
                    data_d   = sel_data;
                    err_d    = 1'b0;
                    consec_d = '0;
                end
                if (deny) begin
                    deny_d   = (deny_q == 8'hFF) ? deny_q : deny_q + 8'd1;
                    consec_d = consec_inc;
                    if (consec_inc >= DENY_LIMIT_C) alarm_d = 1'b1;
                end
            end
            RESP: begin
                if (rd_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            deny_q   <= '0;
            consec_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            deny_q   <= deny_d;
            consec_q <= consec_d;
            alarm_q  <= alarm_d;
        end
    end

    assign rd_ready      = ready_q;
    assign rd_valid      = valid_q;
    assign rd_data       = data_q;
    assign rd_err        = err_q;
    assign deny_cnt      = deny_q;
    assign lockout_alarm = alarm_q;

endmodule

// File: tb/tb_lock_reg_readback.sv
// Self-checking bench for lock_reg_readback: directed plan plus randomized reads against a rule-based model.
module tb_lock_reg_readback;

    logic         Clk = 1'b0;
    logic         resetn;
    logic [31:0]  regs [4];
    logic [127:0] reg_data_flat;
    logic         lock_status;
    logic         debug_unlocked;
    logic         rd_req;
    logic [3:0]   rd_addr;
    logic         rd_ready;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         rd_err;
    logic         rd_resp_ready;
    logic [7:0]   deny_cnt;
    logic         lockout_alarm;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    int m_deny;
    int m_consec;
    bit m_alarm;

    always #5 Clk = ~Clk;

    assign reg_data_flat = {regs[3], regs[2], regs[1], regs[0]};

    lock_reg_readback dut (
        .Clk(Clk), .resetn(resetn), .reg_data_flat(reg_data_flat),
        .lock_status(lock_status), .debug_unlocked(debug_unlocked),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .rd_resp_ready(rd_resp_ready), .deny_cnt(deny_cnt),
        .lockout_alarm(lockout_alarm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_deny   = 0;
        m_consec = 0;
        m_alarm  = 0;
    endtask

    // Apply the result rules to one read; returns the expected response.
    task automatic model_read(input int addr, output logic [31:0] exp_data, output logic exp_err);
        bit denied = 0;
        bit secret = (addr == 3);
        bit bypass = 0;
`ifdef DEBUG_READ_BYPASS_EN
        bypass = debug_unlocked;
`endif
        exp_data = 32'h0;
        exp_err  = 1'b1;
        if (m_alarm)                                  denied = 1;
        else if (addr >= 4)                           denied = 0;
        else if (secret && lock_status && !bypass)    denied = 1;
        else begin
            exp_data = regs[addr];
            exp_err  = 1'b0;
            m_consec = 0;
        end
        if (denied) begin
            if (m_deny < 255)   m_deny++;
            if (m_consec < 255) m_consec++;
            if (m_consec >= 3)  m_alarm = 1;
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        check("rst_ready", rd_ready, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_err", rd_err, 0);
        check("rst_deny", deny_cnt, 0);
        check("rst_alarm", lockout_alarm, 0);
        model_reset();
        @(negedge Clk);
        resetn = 1'b1;
        @(posedge Clk); #1;
        check("rst_first_ready", rd_ready, 1);
    endtask

    // One full transaction; optional stall in RESP with register churn, optional reset in RESP.
    task automatic do_read(input int addr, input int hold, input bit reset_mid);
        logic [31:0] exp_data;
        logic        exp_err;
        int          budget = 20;
        while (!rd_ready && budget > 0) begin
            @(posedge Clk); #1;
            budget--;
        end
        if (!rd_ready) begin
            check("ready_timeout", rd_ready, 1);
            return;
        end
        rd_req  = 1'b1;
        rd_addr = 4'(addr);
        @(posedge Clk); #1;
        rd_req  = 1'b0;
        rd_addr = 4'($urandom_range(0, 15));
        check("lat1_valid", rd_valid, 0);
        check("lat1_ready", rd_ready, 0);
        @(posedge Clk); #1;
        model_read(addr, exp_data, exp_err);
        check("valid", rd_valid, 1);
        check("data", rd_data, exp_data);
        check("err", rd_err, exp_err);
        check("deny_cnt", deny_cnt, 32'(m_deny));
        check("alarm", lockout_alarm, m_alarm);
        for (int k = 0; k < hold; k++) begin
            for (int r = 0; r < 4; r++) regs[r] = $urandom;
            @(posedge Clk); #1;
            check("hold_valid", rd_valid, 1);
            check("hold_data", rd_data, exp_data);
            check("hold_err", rd_err, exp_err);
        end
        if (reset_mid) begin
            apply_reset();
            return;
        end
        rd_resp_ready = 1'b1;
        @(posedge Clk); #1;
        rd_resp_ready = 1'b0;
        check("done_valid", rd_valid, 0);
        check("done_ready", rd_ready, 1);
    endtask

    initial begin
        resetn         = 1'b0;
        lock_status    = 1'b0;
        debug_unlocked = 1'b0;
        rd_req         = 1'b0;
        rd_addr        = '0;
        rd_resp_ready  = 1'b0;
        regs[0] = 32'hA5A5_0001;
        regs[1] = 32'h1111_2222;
        regs[2] = 32'h3333_4444;
        regs[3] = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        apply_reset();

        // Directed plan.
        do_read(0, 0, 0);
        lock_status = 1'b1;
        do_read(3, 0, 0);
        do_read(1, 0, 0);
        for (int i = 0; i < 3; i++) do_read(3, 0, 0);
        do_read(0, 0, 0);
        do_read(9, 5, 0);
        do_read(2, 2, 1);

        // Debug unlock on the secret register (bypass only with the macro).
        regs[3] = 32'hDEAD_BEEF;
        lock_status    = 1'b1;
        debug_unlocked = 1'b1;
        do_read(3, 0, 0);
        debug_unlocked = 1'b0;
        do_read(9, 0, 0);
        do_read(0, 0, 0);

        // Randomized reads; reset occasionally so the alarm does not dominate.
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 4; r++) regs[r] = $urandom;
            lock_status    = ($urandom_range(0, 2) != 0);
            debug_unlocked = ($urandom_range(0, 3) == 0);
            do_read($urandom_range(0, 5), $urandom_range(0, 2), ($urandom_range(0, 19) == 0));
        end

        // Drive deny_cnt into saturation.
        lock_status    = 1'b1;
        debug_unlocked = 1'b0;
        for (int n = 0; n < 260; n++) do_read(3, 0, 0);
        check("deny_sat", deny_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
